// File: rtl/jpeg_stream_seq.sv
// rtl/jpeg_stream_seq.sv - JPEG frame sequencer: header, stuffed ECS and EOI marker repacked into 32-bit words
module jpeg_stream_seq #(
  parameter logic [15:0] EOI_MARKER = 16'hFFD9,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      hdr_data,
  input  logic [2:0]       hdr_nbytes,
  input  logic             hdr_tlast,
  input  logic             hdr_valid,
  output logic             hdr_hold,
  input  logic [63:0]      ecs_data,
  input  logic [3:0]       ecs_nbytes,
  input  logic             ecs_tlast,
  input  logic             ecs_valid,
  output logic             ecs_hold,
  output logic [31:0]      out_data,
  output logic [2:0]       out_nbytes,
  output logic             out_tlast,
  output logic             out_valid,
  input  logic             out_hold,
  output logic [CNT_W-1:0] frame_bytes,
  output logic             frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_ECS   = 3'd2;
  localparam logic [2:0] S_EOI   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]       r_state;
  logic [95:0]      r_buf;
  logic [3:0]       r_fill;
  logic [31:0]      r_out_data;
  logic [2:0]       r_out_nbytes;
  logic             r_out_tlast;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_frame_bytes;

  logic        w_hdr_acc;
  logic        w_ecs_acc;
  logic        w_eoi_push;
  logic [63:0] w_push_raw;
  logic [63:0] w_push_data;
  logic [63:0] w_push_ones;
  logic [3:0]  w_push_n;
  logic [3:0]  w_pop_n;
  logic [3:0]  w_rem;
  logic [2:0]  w_word_n;
  logic        w_out_ready;
  logic        w_load;
  logic        w_out_xfer;
  logic        w_last_xfer;
  logic [95:0] w_buf_next;
  logic [3:0]  w_fill_next;

  // Holds depend only on state and fill so upstream never sees a path from out_hold.
  assign hdr_hold   = !((r_state == S_IDLE) || ((r_state == S_HDR) && (r_fill <= 4'd8)));
  assign ecs_hold   = !((r_state == S_ECS) && (r_fill <= 4'd4));
  assign w_hdr_acc  = hdr_valid & ~hdr_hold;
  assign w_ecs_acc  = ecs_valid & ~ecs_hold;
  assign w_eoi_push = (r_state == S_EOI) && (r_fill <= 4'd10);

  assign w_out_xfer  = r_out_valid & ~out_hold;
  assign w_last_xfer = w_out_xfer & r_out_tlast;
  assign w_out_ready = ~r_out_valid | ~out_hold;
  assign w_load      = w_out_ready & ((r_fill >= 4'd4) | ((r_state == S_FLUSH) & (r_fill != 4'd0)));
  assign w_word_n    = (r_fill >= 4'd4) ? 3'd4 : r_fill[2:0];
  assign w_pop_n     = w_load ? {1'b0, w_word_n} : 4'd0;
  assign w_rem       = r_fill - w_pop_n;

  always_comb begin
    w_push_n   = 4'd0;
    w_push_raw = 64'd0;
    if (w_hdr_acc) begin
      w_push_n   = {1'b0, hdr_nbytes};
      w_push_raw = {hdr_data, 32'd0};
    end else if (w_ecs_acc) begin
      w_push_n   = ecs_nbytes;
      w_push_raw = ecs_data;
    end else if (w_eoi_push) begin
      w_push_n   = 4'd2;
      w_push_raw = {EOI_MARKER, 48'd0};
    end
  end

  // Bytes past nbytes are masked so everything below fill stays zero.
  assign w_push_ones = '1;
  assign w_push_data = w_push_raw & ~(w_push_ones >> {w_push_n, 3'b000});
  assign w_buf_next  = (r_buf << {w_pop_n, 3'b000}) | ({w_push_data, 32'd0} >> {w_rem, 3'b000});
  assign w_fill_next = w_rem + w_push_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_fill        <= 4'd0;
      r_out_data    <= 32'd0;
      r_out_nbytes  <= 3'd0;
      r_out_tlast   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_count       <= '0;
      r_frame_bytes <= '0;
    end else begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;

      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_buf[95:64];
        r_out_nbytes <= w_word_n;
        r_out_tlast  <= (r_state == S_FLUSH) && (r_fill <= 4'd4);
      end else if (w_out_ready) begin
        r_out_valid <= 1'b0;
        r_out_tlast <= 1'b0;
      end

      if (w_last_xfer) begin
        r_frame_bytes <= r_count + {{(CNT_W-3){1'b0}}, r_out_nbytes};
        r_count       <= '0;
      end else if (w_out_xfer) begin
        r_count <= r_count + {{(CNT_W-3){1'b0}}, r_out_nbytes};
      end

      case (r_state)
        S_IDLE:  if (w_hdr_acc) r_state <= hdr_tlast ? S_ECS : S_HDR;
        S_HDR:   if (w_hdr_acc && hdr_tlast) r_state <= S_ECS;
        S_ECS:   if (w_ecs_acc && ecs_tlast) r_state <= S_EOI;
        S_EOI:   if (w_eoi_push) r_state <= S_FLUSH;
        S_FLUSH: if (w_last_xfer) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_nbytes  = r_out_nbytes;
  assign out_tlast   = r_out_tlast;
  assign out_valid   = r_out_valid;
  assign frame_bytes = r_frame_bytes;
  assign frame_done  = w_last_xfer;

  assert property (@(posedge clk) disable iff (!resetn)
    hdr_valid |-> ((hdr_nbytes >= 3'd1) && (hdr_nbytes <= 3'd4)));
  assert property (@(posedge clk) disable iff (!resetn) ecs_valid |-> (ecs_nbytes <= 4'd8));
  assert property (@(posedge clk) disable iff (!resetn) r_fill <= 4'd12);

endmodule
